// File: rtl/ysyx_22050019_axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI read-port arbiter.
// FSM state, grant encoding and AXI response codes.
package ysyx_22050019_axi_rd_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IFU  = 2'd1,
      GNT_LSU  = 2'd2
   } gnt_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_22050019_axi_rd_arbiter_rr_arb2.sv
// Two-input round-robin picker, purely combinational.
// req[0]=IFU, req[1]=LSU; last=1 means LSU won last; gnt is one-hot.
module ysyx_22050019_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       en,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) begin
            // Contention: favour whoever did not win last time
            gnt = last ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

endmodule

// File: rtl/ysyx_22050019_axi_rd_arbiter.sv
// Shares one AXI read port between IFU and LSU, one transaction at a time.
// Ports: IFU/LSU AR+R slave sides, lsu_wr_busy, and the AR+R master side.
module ysyx_22050019_axi_rd_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_ar_valid,
   output logic              ifu_ar_ready,
   input  logic [ADDR_W-1:0] ifu_ar_addr,
   output logic              ifu_r_valid,
   input  logic              ifu_r_ready,
   output logic [DATA_W-1:0] ifu_r_data,
   output logic [1:0]        ifu_r_resp,
   input  logic              lsu_ar_valid,
   output logic              lsu_ar_ready,
   input  logic [ADDR_W-1:0] lsu_ar_addr,
   output logic              lsu_r_valid,
   input  logic              lsu_r_ready,
   output logic [DATA_W-1:0] lsu_r_data,
   output logic [1:0]        lsu_r_resp,
   input  logic              lsu_wr_busy,
   output logic              s_ar_valid,
   input  logic              s_ar_ready,
   output logic [ADDR_W-1:0] s_ar_addr,
   input  logic              s_r_valid,
   output logic              s_r_ready,
   input  logic [DATA_W-1:0] s_r_data,
   input  logic [1:0]        s_r_resp
);
   import ysyx_22050019_axi_rd_arbiter_pkg::*;

   state_e            state_q, state_d;
   gnt_e              gnt_q;
   logic              last_lsu_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        pick;
   logic              r_done;

   // A pending store blocks LSU loads so they cannot overtake it
   ysyx_22050019_rr_arb2 u_arb (
      .req  ({lsu_ar_valid & ~lsu_wr_busy, ifu_ar_valid}),
      .last (last_lsu_q),
      .en   (state_q == ST_IDLE),
      .gnt  (pick)
   );

   assign r_done = (state_q == ST_DATA) && s_r_valid && s_r_ready;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      ifu_ar_ready = 1'b0;
      lsu_ar_ready = 1'b0;
      s_ar_valid   = 1'b0;
      s_ar_addr    = '0;
      s_r_ready    = 1'b0;
      ifu_r_valid  = 1'b0;
      ifu_r_data   = '0;
      ifu_r_resp   = 2'b00;
      lsu_r_valid  = 1'b0;
      lsu_r_data   = '0;
      lsu_r_resp   = 2'b00;
      unique case (state_q)
         ST_IDLE: begin
            ifu_ar_ready = pick[0];
            lsu_ar_ready = pick[1];
            if (|pick) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            s_ar_valid = 1'b1;
            s_ar_addr  = addr_q;
            if (s_ar_ready) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (gnt_q == GNT_IFU) begin
               s_r_ready   = ifu_r_ready;
               ifu_r_valid = s_r_valid;
               ifu_r_data  = s_r_data;
               ifu_r_resp  = s_r_resp;
            end else if (gnt_q == GNT_LSU) begin
               s_r_ready   = lsu_r_ready;
               lsu_r_valid = s_r_valid;
               lsu_r_data  = s_r_data;
               lsu_r_resp  = s_r_resp;
            end
            if (s_r_valid && s_r_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q      <= GNT_NONE;
         last_lsu_q <= 1'b0;
         addr_q     <= '0;
      end else begin
         if (|pick) begin
            gnt_q  <= pick[1] ? GNT_LSU : GNT_IFU;
            addr_q <= pick[1] ? lsu_ar_addr : ifu_ar_addr;
         end
         if (r_done) begin
            last_lsu_q <= (gnt_q == GNT_LSU);
            gnt_q      <= GNT_NONE;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22050019_axi_rd_arbiter.sv
// Randomized bench for the AXI read arbiter against a transaction model.
// The bench plays both masters and the slave.
module tb_ysyx_22050019_axi_rd_arbiter;
   import ysyx_22050019_axi_rd_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_ar_valid, ifu_ar_ready, ifu_r_valid, ifu_r_ready;
   logic [63:0] ifu_ar_addr, ifu_r_data;
   logic [1:0]  ifu_r_resp;
   logic        lsu_ar_valid, lsu_ar_ready, lsu_r_valid, lsu_r_ready;
   logic [63:0] lsu_ar_addr, lsu_r_data;
   logic [1:0]  lsu_r_resp;
   logic        lsu_wr_busy;
   logic        s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
   logic [63:0] s_ar_addr, s_r_data;
   logic [1:0]  s_r_resp;

   always #5 clk = ~clk;

   ysyx_22050019_axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .rst(rst),
      .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(ifu_ar_ready),
      .ifu_ar_addr(ifu_ar_addr), .ifu_r_valid(ifu_r_valid),
      .ifu_r_ready(ifu_r_ready), .ifu_r_data(ifu_r_data),
      .ifu_r_resp(ifu_r_resp),
      .lsu_ar_valid(lsu_ar_valid), .lsu_ar_ready(lsu_ar_ready),
      .lsu_ar_addr(lsu_ar_addr), .lsu_r_valid(lsu_r_valid),
      .lsu_r_ready(lsu_r_ready), .lsu_r_data(lsu_r_data),
      .lsu_r_resp(lsu_r_resp), .lsu_wr_busy(lsu_wr_busy),
      .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
      .s_ar_addr(s_ar_addr), .s_r_valid(s_r_valid),
      .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp)
   );

   int checks = 0;
   int errors = 0;

   // Transaction model: one read in flight, who owns it, whether its
   // address has been accepted, and who won the last completed read.
   bit          inflight = 0;
   bit          sent = 0;
   int          owner = 0;
   int          last_win = 0;
   logic [63:0] m_addr = '0;
   int          n_ifu = 0, n_lsu = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic bit roll(input int pct);
      return $urandom_range(99) < pct;
   endfunction

   task automatic zero_inputs();
      ifu_ar_valid = 0; ifu_ar_addr = '0; ifu_r_ready = 0;
      lsu_ar_valid = 0; lsu_ar_addr = '0; lsu_r_ready = 0;
      lsu_wr_busy  = 0; s_ar_ready  = 0; s_r_valid   = 0;
      s_r_data     = '0; s_r_resp   = OKAY;
   endtask

   task automatic drive(input int p_ifu, input int p_lsu, input int p_busy,
                        input int p_sar, input int p_srv, input int p_rr);
      ifu_ar_valid = roll(p_ifu);
      lsu_ar_valid = roll(p_lsu);
      lsu_wr_busy  = roll(p_busy);
      s_ar_ready   = roll(p_sar);
      s_r_valid    = roll(p_srv);
      ifu_r_ready  = roll(p_rr);
      lsu_r_ready  = roll(p_rr);
      ifu_ar_addr  = roll(50) ? 64'h8000_0000 : {$urandom, $urandom};
      lsu_ar_addr  = roll(50) ? 64'h8000_1000 : {$urandom, $urandom};
      s_r_data     = roll(30) ? 64'h0000_0013_0000_0093
                              : {$urandom, $urandom};
      s_r_resp     = roll(70) ? OKAY : 2'($urandom_range(3));
   endtask

   task automatic compare_update();
      int          win;
      logic        e_iar, e_lar, e_sav, e_srr, e_irv, e_lrv;
      logic [63:0] e_saa, e_ird, e_lrd;
      logic [1:0]  e_irs, e_lrs;
      bit          ie, le;
      win = -1;
      e_iar = 0; e_lar = 0; e_sav = 0; e_saa = '0; e_srr = 0;
      e_irv = 0; e_ird = '0; e_irs = 0;
      e_lrv = 0; e_lrd = '0; e_lrs = 0;
      if (!inflight) begin
         ie = ifu_ar_valid;
         le = lsu_ar_valid && !lsu_wr_busy;
         if (ie && le) win = (last_win == 0) ? 1 : 0;
         else if (ie)  win = 0;
         else if (le)  win = 1;
         e_iar = (win == 0);
         e_lar = (win == 1);
      end else if (!sent) begin
         e_sav = 1;
         e_saa = m_addr;
      end else if (owner == 0) begin
         e_srr = ifu_r_ready;
         e_irv = s_r_valid; e_ird = s_r_data; e_irs = s_r_resp;
      end else begin
         e_srr = lsu_r_ready;
         e_lrv = s_r_valid; e_lrd = s_r_data; e_lrs = s_r_resp;
      end
      chk("ifu_ar_ready", ifu_ar_ready, e_iar);
      chk("lsu_ar_ready", lsu_ar_ready, e_lar);
      chk("s_ar_valid", s_ar_valid, e_sav);
      chk("s_ar_addr", s_ar_addr, e_saa);
      chk("s_r_ready", s_r_ready, e_srr);
      chk("ifu_r_valid", ifu_r_valid, e_irv);
      chk("ifu_r_data", ifu_r_data, e_ird);
      chk("ifu_r_resp", ifu_r_resp, e_irs);
      chk("lsu_r_valid", lsu_r_valid, e_lrv);
      chk("lsu_r_data", lsu_r_data, e_lrd);
      chk("lsu_r_resp", lsu_r_resp, e_lrs);
      // Advance the model using the handshakes it predicted
      if (!inflight) begin
         if (win >= 0) begin
            inflight = 1;
            sent     = 0;
            owner    = win;
            m_addr   = (win == 0) ? ifu_ar_addr : lsu_ar_addr;
            if (win == 0) n_ifu++;
            else          n_lsu++;
         end
      end else if (!sent) begin
         if (s_ar_ready) sent = 1;
      end else if (s_r_valid && e_srr) begin
         inflight = 0;
         last_win = owner;
      end
   endtask

   task automatic step(input int p_ifu, input int p_lsu, input int p_busy,
                       input int p_sar, input int p_srv, input int p_rr);
      @(posedge clk);
      #1;
      drive(p_ifu, p_lsu, p_busy, p_sar, p_srv, p_rr);
      #2;
      compare_update();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      zero_inputs();
      #2;
      chk("rst_ifu_ar_ready", ifu_ar_ready, 0);
      chk("rst_lsu_ar_ready", lsu_ar_ready, 0);
      chk("rst_s_ar_valid", s_ar_valid, 0);
      chk("rst_s_ar_addr", s_ar_addr, 0);
      chk("rst_s_r_ready", s_r_ready, 0);
      chk("rst_ifu_r_valid", ifu_r_valid, 0);
      chk("rst_ifu_r_data", ifu_r_data, 0);
      chk("rst_ifu_r_resp", ifu_r_resp, 0);
      chk("rst_lsu_r_valid", lsu_r_valid, 0);
      chk("rst_lsu_r_data", lsu_r_data, 0);
      chk("rst_lsu_r_resp", lsu_r_resp, 0);
      inflight = 0;
      sent     = 0;
      last_win = 0;
   endtask

   initial begin
      rst = 1;
      zero_inputs();
      repeat (2) @(posedge clk);
      do_reset();
      // IFU alone, zero-wait slave and master
      repeat (200) step(100, 0, 0, 100, 100, 100);
      // Both always requesting: strict alternation, LSU first
      do_reset();
      repeat (300) step(100, 100, 0, 100, 100, 100);
      // LSU only with a frequently busy store path
      repeat (300) step(0, 100, 70, 100, 100, 100);
      // Slow slave address and data channels
      repeat (400) step(60, 60, 20, 30, 40, 100);
      // Slow masters on the R channel
      repeat (400) step(60, 60, 20, 80, 90, 30);
      // Fully random, with occasional resets mid-transaction
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(59) == 0) do_reset();
         else step(50, 50, 30, 50, 50, 50);
      end
      chk("ifu_served", 64'(n_ifu > 0), 1);
      chk("lsu_served", 64'(n_lsu > 0), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
